// File: rtl/pid_wb_master_if.sv
// Wishbone classic bus between the PID sequencer (master) and the pid_simple register slave.
interface pid_wb_master_if #(
  parameter int unsigned WbNb    = 16,
  parameter int unsigned AdrWbNb = 16
) ();
  logic               cyc;
  logic               stb;
  logic               we;
  logic [AdrWbNb-1:0] adr;
  logic [WbNb-1:0]    wdata;
  logic               ack;
  logic [WbNb-1:0]    rdata;

  modport master (output cyc, stb, we, adr, wdata, input ack, rdata);
  modport slave  (input cyc, stb, we, adr, wdata, output ack, rdata);
endinterface

// File: rtl/pid_wb_master.sv
// Wishbone initiator that programs the pid_simple coefficients and then runs one
// write-pv / read-un / read-overflow step for every accepted process sample.
module pid_wb_master #(
  parameter int unsigned WbNb    = 16,
  parameter int unsigned AdrWbNb = 16,
  parameter int unsigned KpAdr   = 0,
  parameter int unsigned KiAdr   = 1,
  parameter int unsigned KdAdr   = 2,
  parameter int unsigned SpAdr   = 3,
  parameter int unsigned PvAdr   = 4,
  parameter int unsigned UnAdr   = 8,
  parameter int unsigned OfAdr   = 10,
  parameter int unsigned Timeout = 255
) (
  input  logic            clk,
  input  logic            rst,
  pid_wb_master_if.master wb,
  input  logic            cfg_start,
  input  logic [15:0]     kp,
  input  logic [15:0]     ki,
  input  logic [15:0]     kd,
  input  logic [15:0]     sp,
  output logic            cfg_done,
  input  logic            pv_valid,
  input  logic [15:0]     pv,
  output logic            pv_ready,
  output logic [31:0]     un,
  output logic            un_valid,
  output logic            of,
  output logic            err
);

  localparam logic [7:0] CntLast = 8'(Timeout - 1);

  typedef enum logic [3:0] {
    StIdle, StCfgKp, StCfgKi, StCfgKd, StCfgSp, StReady, StPvWr, StUnRd, StOfRd
  } state_e;

  state_e             state_q, state_d;
  logic               cyc_q, cyc_d, we_q, we_d;
  logic [AdrWbNb-1:0] adr_q, adr_d;
  logic [WbNb-1:0]    wdata_q, wdata_d, un_rd_q, un_rd_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [15:0]        kp_q, kp_d, ki_q, ki_d, kd_q, kd_d, sp_q, sp_d, pv_q, pv_d;
  logic [31:0]        un_q, un_d;
  logic               of_q, of_d, err_q, err_d, cfg_done_q, cfg_done_d, un_valid_q, un_valid_d;

  // Per-state bus transaction description
  logic [AdrWbNb-1:0] tx_adr;
  logic [WbNb-1:0]    tx_data;
  logic               tx_we, tx_cfg, in_tx;
  state_e             tx_next;

  always_comb begin
    tx_adr  = '0;
    tx_data = '0;
    tx_we   = 1'b0;
    tx_cfg  = 1'b0;
    tx_next = StReady;
    in_tx   = 1'b1;
    unique case (state_q)
      StCfgKp: begin
        tx_adr = AdrWbNb'(KpAdr); tx_data = WbNb'(kp_q); tx_we = 1'b1; tx_cfg = 1'b1;
        tx_next = StCfgKi;
      end
      StCfgKi: begin
        tx_adr = AdrWbNb'(KiAdr); tx_data = WbNb'(ki_q); tx_we = 1'b1; tx_cfg = 1'b1;
        tx_next = StCfgKd;
      end
      StCfgKd: begin
        tx_adr = AdrWbNb'(KdAdr); tx_data = WbNb'(kd_q); tx_we = 1'b1; tx_cfg = 1'b1;
        tx_next = StCfgSp;
      end
      StCfgSp: begin
        tx_adr = AdrWbNb'(SpAdr); tx_data = WbNb'(sp_q); tx_we = 1'b1; tx_cfg = 1'b1;
        tx_next = StReady;
      end
      StPvWr: begin
        tx_adr = AdrWbNb'(PvAdr); tx_data = WbNb'(pv_q); tx_we = 1'b1; tx_next = StUnRd;
      end
      StUnRd:  begin tx_adr = AdrWbNb'(UnAdr); tx_next = StOfRd; end
      StOfRd:  begin tx_adr = AdrWbNb'(OfAdr); tx_next = StReady; end
      default: in_tx = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    we_d       = we_q;
    adr_d      = adr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    kp_d       = kp_q;
    ki_d       = ki_q;
    kd_d       = kd_q;
    sp_d       = sp_q;
    pv_d       = pv_q;
    un_rd_d    = un_rd_q;
    un_d       = un_q;
    of_d       = of_q;
    err_d      = err_q;
    cfg_done_d = 1'b0;
    un_valid_d = 1'b0;
    pv_ready   = 1'b0;

    if (state_q == StIdle || state_q == StReady) begin
      pv_ready = (state_q == StReady) && !cfg_start;
      if (cfg_start) begin
        kp_d    = kp;
        ki_d    = ki;
        kd_d    = kd;
        sp_d    = sp;
        err_d   = 1'b0;
        state_d = StCfgKp;
      end else if (pv_ready && pv_valid) begin
        pv_d    = pv;
        state_d = StPvWr;
      end
    end

    // A transaction state with the bus idle means we just entered it: issue now.
    if (in_tx) begin
      if (!cyc_q) begin
        cyc_d   = 1'b1;
        we_d    = tx_we;
        adr_d   = tx_adr;
        wdata_d = tx_data;
        cnt_d   = '0;
      end else if (wb.ack) begin
        cyc_d   = 1'b0;
        we_d    = 1'b0;
        adr_d   = '0;
        wdata_d = '0;
        state_d = tx_next;
        if (state_q == StCfgSp) cfg_done_d = 1'b1;
        if (state_q == StUnRd)  un_rd_d = wb.rdata;
        if (state_q == StOfRd) begin
          un_d       = 32'($signed(un_rd_q));
          of_d       = wb.rdata[0];
          un_valid_d = 1'b1;
        end
      end else if (cnt_q == CntLast) begin
        cyc_d   = 1'b0;
        we_d    = 1'b0;
        adr_d   = '0;
        wdata_d = '0;
        err_d   = 1'b1;
        state_d = tx_cfg ? StIdle : StReady;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cyc_q      <= 1'b0;
      we_q       <= 1'b0;
      adr_q      <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      kp_q       <= '0;
      ki_q       <= '0;
      kd_q       <= '0;
      sp_q       <= '0;
      pv_q       <= '0;
      un_rd_q    <= '0;
      un_q       <= '0;
      of_q       <= 1'b0;
      err_q      <= 1'b0;
      cfg_done_q <= 1'b0;
      un_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      we_q       <= we_d;
      adr_q      <= adr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      kp_q       <= kp_d;
      ki_q       <= ki_d;
      kd_q       <= kd_d;
      sp_q       <= sp_d;
      pv_q       <= pv_d;
      un_rd_q    <= un_rd_d;
      un_q       <= un_d;
      of_q       <= of_d;
      err_q      <= err_d;
      cfg_done_q <= cfg_done_d;
      un_valid_q <= un_valid_d;
    end
  end

  assign wb.cyc   = cyc_q;
  assign wb.stb   = cyc_q;
  assign wb.we    = we_q;
  assign wb.adr   = adr_q;
  assign wb.wdata = wdata_q;
  assign cfg_done = cfg_done_q;
  assign un       = un_q;
  assign un_valid = un_valid_q;
  assign of       = of_q;
  assign err      = err_q;

endmodule

// File: tb/tb_pid_wb_master.sv
// Directed bench for pid_wb_master: behavioural WB slave with wait states / no-ack,
// a transaction logger, and one task per scenario.
module tb_pid_wb_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_start = 1'b0;
  logic [15:0] kp = '0, ki = '0, kd = '0, sp = '0, pv = '0;
  logic        pv_valid = 1'b0;
  logic        cfg_done, pv_ready, un_valid, of, err;
  logic [31:0] un;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pid_wb_master_if #(.WbNb(16), .AdrWbNb(16)) wb ();

  pid_wb_master #(.WbNb(16), .AdrWbNb(16), .Timeout(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .wb        (wb),
    .cfg_start (cfg_start),
    .kp        (kp),
    .ki        (ki),
    .kd        (kd),
    .sp        (sp),
    .cfg_done  (cfg_done),
    .pv_valid  (pv_valid),
    .pv        (pv),
    .pv_ready  (pv_ready),
    .un        (un),
    .un_valid  (un_valid),
    .of        (of),
    .err       (err)
  );

  // Slave: acks after ack_waits wait states; optionally never acks the un register.
  int          ack_waits = 0;
  int          wcnt = 0;
  bit          no_ack_en = 1'b0;
  logic [15:0] un_val = 16'h8001;
  logic        of_val = 1'b1;

  assign wb.ack   = wb.stb && (wcnt == ack_waits) && !(no_ack_en && wb.adr == 16'd8);
  assign wb.rdata = (wb.adr == 16'd8) ? un_val : (wb.adr == 16'd10) ? {15'd0, of_val} : 16'h0;

  always @(posedge clk) wcnt <= (wb.stb && !wb.ack) ? wcnt + 1 : 0;

  // Completed-transaction log: we, adr, data, stb-high cycles, idle gap before, held stable
  typedef struct packed {
    logic        we;
    logic [15:0] adr;
    logic [15:0] dat;
    logic [7:0]  len;
    logic [7:0]  gap;
    logic        stable;
  } rec_t;

  rec_t        log_q[$];
  int          run_q = 0, idle_q = 0, gap_q = 0;
  bit          stable_q = 1'b1;
  logic        st_we = 1'b0;
  logic [15:0] st_adr = '0, st_dat = '0;
  logic        same;
  int          unv_cnt = 0, done_cnt = 0;

  assign same = (wb.we == st_we) && (wb.adr == st_adr) && (wb.wdata == st_dat);

  always @(posedge clk) begin
    if (un_valid) unv_cnt <= unv_cnt + 1;
    if (cfg_done) done_cnt <= done_cnt + 1;
    if (wb.stb) begin
      idle_q <= 0;
      if (wb.ack) begin
        log_q.push_back(rec_t'({wb.we, wb.adr, wb.wdata, 8'(run_q + 1),
                                8'((run_q == 0) ? idle_q : gap_q),
                                (run_q == 0) || (stable_q && same)}));
        run_q <= 0;
      end else begin
        run_q <= run_q + 1;
        if (run_q == 0) begin
          st_we    <= wb.we;
          st_adr   <= wb.adr;
          st_dat   <= wb.wdata;
          stable_q <= 1'b1;
          gap_q    <= idle_q;
        end else begin
          stable_q <= stable_q && same;
        end
      end
    end else begin
      idle_q <= idle_q + 1;
      run_q  <= 0;
    end
  end

  task automatic do_cfg(input logic [15:0] a, b, c, d, output int lat);
    @(negedge clk);
    cfg_start = 1'b1; kp = a; ki = b; kd = c; sp = d;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    lat = 0;
    while (!cfg_done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic do_pv(input logic [15:0] p, output int lat, output int pulses);
    int u0;
    u0 = unv_cnt;
    @(negedge clk);
    pv_valid = 1'b1; pv = p;
    @(posedge clk); #1;
    pv_valid = 1'b0;
    lat = 0;
    while (!un_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    @(posedge clk); #1;
    pulses = unv_cnt - u0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (wb.cyc !== 1'b0 || wb.stb !== 1'b0) begin fails++;
      $display("FAIL reset_bus cyc=%b stb=%b required 0", wb.cyc, wb.stb); end
    tests++; if (pv_ready !== 1'b0) begin fails++;
      $display("FAIL reset_pv_ready got %b required 0", pv_ready); end
    tests++; if (un !== 32'h0 || of !== 1'b0 || err !== 1'b0) begin fails++;
      $display("FAIL reset_outputs un=%h of=%b err=%b required 0", un, of, err); end
    tests++; if (cfg_done !== 1'b0 || un_valid !== 1'b0) begin fails++;
      $display("FAIL reset_pulses done=%b unv=%b required 0", cfg_done, un_valid); end
    rst = 1'b0;
  endtask

  task automatic test_config();
    int          lat, base;
    rec_t        r;
    logic [15:0] exp_d[4];
    exp_d = '{16'h0010, 16'h0020, 16'h0030, 16'h0400};
    base  = log_q.size();
    do_cfg(16'h0010, 16'h0020, 16'h0030, 16'h0400, lat);
    tests++; if (lat !== 8) begin fails++;
      $display("FAIL cfg_latency got %0d required 8", lat); end
    tests++; if (log_q.size() - base !== 4) begin fails++;
      $display("FAIL cfg_count got %0d required 4", log_q.size() - base); end
    for (int i = 0; i < 4; i++) begin
      if (base + i < log_q.size()) begin
        r = log_q[base + i];
        tests++;
        if (r.we !== 1'b1 || r.adr !== 16'(i) || r.dat !== exp_d[i] || r.len !== 8'd1 ||
            !r.stable || (i > 0 && r.gap !== 8'd1)) begin
          fails++;
          $display("FAIL cfg_write%0d got we=%b adr=%h dat=%h len=%0d gap=%0d required we=1 adr=%h dat=%h len=1 gap=1",
                   i, r.we, r.adr, r.dat, r.len, r.gap, 16'(i), exp_d[i]);
        end
      end
    end
    @(posedge clk); #1;
    tests++; if (cfg_done !== 1'b0 || pv_ready !== 1'b1) begin fails++;
      $display("FAIL cfg_after done=%b pv_ready=%b required 0 1", cfg_done, pv_ready); end
  endtask

  task automatic test_pv_step(input int waits);
    int          lat, pulses, base;
    rec_t        r;
    logic [15:0] exp_a[3];
    logic [15:0] exp_v[3];
    logic        exp_w[3];
    exp_a = '{16'd4, 16'd8, 16'd10};
    exp_v = '{16'h0123, 16'h0000, 16'h0000};
    exp_w = '{1'b1, 1'b0, 1'b0};
    ack_waits = waits; un_val = 16'h8001; of_val = 1'b1;
    base = log_q.size();
    do_pv(16'h0123, lat, pulses);
    tests++; if (lat !== 6 + 3 * waits) begin fails++;
      $display("FAIL pv_latency_w%0d got %0d required %0d", waits, lat, 6 + 3 * waits); end
    tests++; if (un !== 32'hFFFF8001 || of !== 1'b1) begin fails++;
      $display("FAIL pv_result_w%0d got un=%h of=%b required FFFF8001 1", waits, un, of); end
    tests++; if (pulses !== 1) begin fails++;
      $display("FAIL pv_pulses_w%0d got %0d required 1", waits, pulses); end
    tests++; if (log_q.size() - base !== 3) begin fails++;
      $display("FAIL pv_count_w%0d got %0d required 3", waits, log_q.size() - base); end
    for (int i = 0; i < 3; i++) begin
      if (base + i < log_q.size()) begin
        r = log_q[base + i];
        tests++;
        if (r.we !== exp_w[i] || r.adr !== exp_a[i] || r.dat !== exp_v[i] ||
            r.len !== 8'(waits + 1) || !r.stable || (i > 0 && r.gap !== 8'd1)) begin
          fails++;
          $display("FAIL pv_tx%0d_w%0d got we=%b adr=%h dat=%h len=%0d gap=%0d stable=%b required we=%b adr=%h dat=%h len=%0d gap=1 stable=1",
                   i, waits, r.we, r.adr, r.dat, r.len, r.gap, r.stable,
                   exp_w[i], exp_a[i], exp_v[i], waits + 1);
        end
      end
    end
    ack_waits = 0;
  endtask

  task automatic test_timeout();
    int n, k, u0, lat, pulses;
    no_ack_en = 1'b1;
    u0 = unv_cnt;
    @(negedge clk);
    pv_valid = 1'b1; pv = 16'h0200;
    @(posedge clk); #1;
    pv_valid = 1'b0;
    n = 0; k = 0;
    while (!err && k < 50) begin
      @(posedge clk); #1;
      k++;
      if (wb.stb && wb.adr == 16'd8) n++;
    end
    tests++; if (err !== 1'b1 || n !== 5) begin fails++;
      $display("FAIL timeout_abort got err=%b stb_cycles=%0d required 1 5", err, n); end
    @(posedge clk); #1;
    tests++; if (wb.cyc !== 1'b0 || pv_ready !== 1'b1) begin fails++;
      $display("FAIL timeout_state cyc=%b pv_ready=%b required 0 1", wb.cyc, pv_ready); end
    tests++; if (un !== 32'hFFFF8001 || unv_cnt !== u0) begin fails++;
      $display("FAIL timeout_un got un=%h pulses=%0d required FFFF8001 0", un, unv_cnt - u0); end
    no_ack_en = 1'b0; un_val = 16'h0042; of_val = 1'b0;
    do_pv(16'h0201, lat, pulses);
    tests++; if (un !== 32'h00000042 || of !== 1'b0 || pulses !== 1 || err !== 1'b1) begin
      fails++;
      $display("FAIL timeout_next got un=%h of=%b pulses=%0d err=%b required 00000042 0 1 1",
               un, of, pulses, err);
    end
    do_cfg(16'h0010, 16'h0020, 16'h0030, 16'h0400, lat);
    tests++; if (err !== 1'b0 || lat !== 8) begin fails++;
      $display("FAIL timeout_clear got err=%b lat=%0d required 0 8", err, lat); end
  endtask

  task automatic test_cfg_priority();
    int          lat, base;
    rec_t        r;
    logic [15:0] exp_d[4];
    exp_d = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    base  = log_q.size();
    @(negedge clk);
    cfg_start = 1'b1; pv_valid = 1'b1; pv = 16'h0555;
    kp = 16'h1111; ki = 16'h2222; kd = 16'h3333; sp = 16'h4444;
    #1;
    tests++; if (pv_ready !== 1'b0) begin fails++;
      $display("FAIL prio_ready got %b required 0", pv_ready); end
    @(posedge clk); #1;
    cfg_start = 1'b0; pv_valid = 1'b0;
    lat = 0;
    while (!cfg_done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    tests++; if (log_q.size() - base !== 4 || lat !== 8) begin fails++;
      $display("FAIL prio_count got %0d lat=%0d required 4 8", log_q.size() - base, lat); end
    for (int i = 0; i < 4; i++) begin
      if (base + i < log_q.size()) begin
        r = log_q[base + i];
        tests++;
        if (r.we !== 1'b1 || r.adr !== 16'(i) || r.dat !== exp_d[i]) begin
          fails++;
          $display("FAIL prio_write%0d got adr=%h dat=%h required adr=%h dat=%h",
                   i, r.adr, r.dat, 16'(i), exp_d[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int seen, lat;
    ack_waits = 3;
    @(negedge clk);
    pv_valid = 1'b1; pv = 16'h0777;
    @(posedge clk); #1;
    pv_valid = 1'b0;
    @(posedge clk); #1;
    tests++; if (wb.stb !== 1'b1 || wb.adr !== 16'd4) begin fails++;
      $display("FAIL rstmid_pre got stb=%b adr=%h required 1 0004", wb.stb, wb.adr); end
    rst = 1'b1;
    @(posedge clk); #1;
    tests++; if (wb.cyc !== 1'b0 || wb.stb !== 1'b0 || wb.we !== 1'b0) begin fails++;
      $display("FAIL rstmid_bus got cyc=%b stb=%b we=%b required 0", wb.cyc, wb.stb, wb.we); end
    tests++; if (un !== 32'h0 || of !== 1'b0 || err !== 1'b0 || un_valid !== 1'b0 ||
                 cfg_done !== 1'b0 || pv_ready !== 1'b0) begin fails++;
      $display("FAIL rstmid_outputs got un=%h of=%b err=%b unv=%b done=%b rdy=%b required 0",
               un, of, err, un_valid, cfg_done, pv_ready);
    end
    rst = 1'b0; ack_waits = 0;
    pv_valid = 1'b1; pv = 16'h0888;
    seen = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (pv_ready || wb.stb) seen++;
    end
    pv_valid = 1'b0;
    tests++; if (seen !== 0) begin fails++;
      $display("FAIL rstmid_refuse got %0d active cycles required 0", seen); end
    do_cfg(16'h0001, 16'h0002, 16'h0003, 16'h0004, lat);
    tests++; if (pv_ready !== 1'b1 || lat !== 8) begin fails++;
      $display("FAIL rstmid_recfg got pv_ready=%b lat=%0d required 1 8", pv_ready, lat); end
  endtask

  initial begin
    test_reset();
    test_config();
    test_pv_step(0);
    test_pv_step(3);
    test_timeout();
    test_cfg_priority();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog run did not complete");
    $fatal(1, "watchdog");
  end

endmodule
